// File: rtl/offnariscv_axis_pkg.sv
// Shared AXI-Stream constants and helpers for the arbiter and its round-robin picker.
package offnariscv_axis_pkg;

    localparam int DEFAULT_N_REQ = 4;

    // clog2 that never returns 0, so a 1- or 2-input block still gets a usable ID field.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: valid/ready handshake plus data.
interface axis_if #(
    parameter int TDATA_WIDTH = 32
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module rr_picker
    import offnariscv_axis_pkg::*;
#(
    parameter int N_REQ    = DEFAULT_N_REQ,
    parameter int ID_WIDTH = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0]    req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [N_REQ-1:0]    grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    logic [ID_WIDTH-1:0] w_cand;

    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_WIDTH'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_cand    = '0;
        // Scan from the farthest candidate back towards ptr so the nearest requester wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = wrap_idx(ptr, k);
            if (req[w_cand]) begin
                grant         = '0;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-input AXI-Stream round-robin merger with a registered main/skid output stage and source-ID sideband.
module axis_rr_arbiter
    import offnariscv_axis_pkg::*;
#(
    parameter int N_REQ    = DEFAULT_N_REQ,
    parameter int ID_WIDTH = id_width(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    axis_if.s                   axis_sif [N_REQ],
    axis_if.m                   axis_mif,
    output logic [ID_WIDTH-1:0] m_src_id,
    input  logic                flush
);

    localparam int TDATA_WIDTH = $bits(axis_mif.tdata);

    logic [N_REQ-1:0]       w_req;
    logic [N_REQ-1:0]       w_grant;
    logic [ID_WIDTH-1:0]    w_grant_idx;
    logic [ID_WIDTH-1:0]    w_ptr_next;
    logic [TDATA_WIDTH-1:0] w_sdata [N_REQ];
    logic                   w_can_accept;
    logic                   w_accept;
    logic                   w_out_hs;

    logic                   r_active;
    logic [ID_WIDTH-1:0]    r_ptr;
    logic                   r_main_valid;
    logic [TDATA_WIDTH-1:0] r_main_data;
    logic [ID_WIDTH-1:0]    r_main_id;
    logic                   r_skid_valid;
    logic [TDATA_WIDTH-1:0] r_skid_data;
    logic [ID_WIDTH-1:0]    r_skid_id;

    if (N_REQ < 2) begin : g_nreq_err
        $fatal(1, "axis_rr_arbiter: N_REQ must be at least 2");
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_in
        if ($bits(axis_sif[g].tdata) != TDATA_WIDTH) begin : g_width_err
            $fatal(1, "axis_rr_arbiter: axis_sif[%0d] TDATA_WIDTH differs from axis_mif", g);
        end
        assign w_req[g]           = axis_sif[g].tvalid;
        assign w_sdata[g]         = axis_sif[g].tdata;
        assign axis_sif[g].tready = w_can_accept & w_grant[g];
    end

    rr_picker #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req       (w_req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // r_active keeps every tready low for the first cycle after reset release.
    assign w_can_accept = rst_n && r_active && !r_skid_valid && !flush;
    assign w_accept     = w_can_accept && (|w_req);
    assign w_out_hs     = r_main_valid && axis_mif.tready;
    assign w_ptr_next   = (w_grant_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : w_grant_idx + ID_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active     <= 1'b0;
            r_ptr        <= '0;
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_id    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_id    <= '0;
        end else begin
            r_active <= 1'b1;
            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_ptr        <= '0;
            end else begin
                if (w_accept) r_ptr <= w_ptr_next;
                // A full skid blocks accepts, so only the skid->main move can happen here.
                if (r_skid_valid) begin
                    if (axis_mif.tready) begin
                        r_main_data  <= r_skid_data;
                        r_main_id    <= r_skid_id;
                        r_skid_valid <= 1'b0;
                    end
                end else if (w_accept) begin
                    if (!r_main_valid || axis_mif.tready) begin
                        r_main_valid <= 1'b1;
                        r_main_data  <= w_sdata[w_grant_idx];
                        r_main_id    <= w_grant_idx;
                    end else begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= w_sdata[w_grant_idx];
                        r_skid_id    <= w_grant_idx;
                    end
                end else if (w_out_hs) begin
                    r_main_valid <= 1'b0;
                end
            end
        end
    end

    assign axis_mif.tvalid = r_main_valid;
    assign axis_mif.tdata  = r_main_data;
    assign m_src_id        = r_main_id;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: vector table, directed corner sequences, random vs queue model.
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct {
        logic [3:0]  vld;
        logic        rdy;
        logic        exp_tvalid;
        logic [31:0] exp_data;
        logic [1:0]  exp_id;
        logic [3:0]  exp_tready;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  id;
    } mbeat_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          flush    = 1'b0;
    logic          m_ready  = 1'b0;
    logic [N-1:0]  tb_valid = '0;
    logic [DW-1:0] tb_data [N];
    logic [N-1:0]  tb_ready;
    logic [1:0]    m_src_id;

    int n_checks = 0;
    int n_errors = 0;

    mbeat_t mq[$];
    int     m_ptr    = 0;
    bit     m_active = 1'b0;

    axis_if #(.TDATA_WIDTH(DW)) sif [N] ();
    axis_if #(.TDATA_WIDTH(DW)) mif ();

    for (genvar g = 0; g < N; g++) begin : g_src
        assign sif[g].tvalid = tb_valid[g];
        assign sif[g].tdata  = tb_data[g];
        assign tb_ready[g]   = sif[g].tready;
    end
    assign mif.tready = m_ready;

    axis_rr_arbiter #(
        .N_REQ    (N),
        .ID_WIDTH (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axis_sif (sif),
        .axis_mif (mif),
        .m_src_id (m_src_id),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_tready"}, 32'(tb_ready), 32'h0);
        tick();
        chk({tag, ".rst_tvalid"}, 32'(mif.tvalid), 32'h0);
        chk({tag, ".rst_tdata"}, mif.tdata, 32'h0);
        chk({tag, ".rst_id"}, 32'(m_src_id), 32'h0);
        chk({tag, ".rst_tready2"}, 32'(tb_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        mq.delete();
        m_ptr    = 0;
        m_active = 1'b0;
    endtask

    // Called with inputs already driven for this cycle; checks, then advances one clock.
    task automatic expect_cyc(input string tag, input logic tv, input logic [31:0] d,
                              input logic [1:0] id, input logic [3:0] tr);
        #1;
        chk({tag, ".tready"}, 32'(tb_ready), 32'(tr));
        chk({tag, ".tvalid"}, 32'(mif.tvalid), 32'(tv));
        if (tv) begin
            chk({tag, ".tdata"}, mif.tdata, d);
            chk({tag, ".id"}, 32'(m_src_id), 32'(id));
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int mdl_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    vec_t tbl [10];

    bit          src_v   [N];
    logic [31:0] src_d   [N];
    int          src_seq [N];
    int          wait_cnt[N];
    int          rdy_pct, vld_pct, g;
    bit          can;
    logic [3:0]  exp_tr;
    mbeat_t      nb;

    initial begin
        for (int i = 0; i < N; i++) tb_data[i] = '0;

        // Always-valid inputs, always-ready sink: strict 0,1,2,3 rotation after one idle cycle.
        tbl[0] = '{4'hF, 1'b1, 1'b0, 32'h00, 2'd0, 4'h0};
        tbl[1] = '{4'hF, 1'b1, 1'b0, 32'h00, 2'd0, 4'h1};
        tbl[2] = '{4'hF, 1'b1, 1'b1, 32'hA0, 2'd0, 4'h2};
        tbl[3] = '{4'hF, 1'b1, 1'b1, 32'hA1, 2'd1, 4'h4};
        tbl[4] = '{4'hF, 1'b1, 1'b1, 32'hA2, 2'd2, 4'h8};
        tbl[5] = '{4'hF, 1'b1, 1'b1, 32'hA3, 2'd3, 4'h1};
        tbl[6] = '{4'hF, 1'b1, 1'b1, 32'hA0, 2'd0, 4'h2};
        tbl[7] = '{4'hF, 1'b1, 1'b1, 32'hA1, 2'd1, 4'h4};
        tbl[8] = '{4'hF, 1'b1, 1'b1, 32'hA2, 2'd2, 4'h8};
        tbl[9] = '{4'hF, 1'b1, 1'b1, 32'hA3, 2'd3, 4'h1};

        do_reset("t34");
        for (int i = 0; i < N; i++) tb_data[i] = 32'hA0 + 32'(i);
        for (int r = 0; r < 10; r++) begin
            tb_valid = tbl[r].vld;
            m_ready  = tbl[r].rdy;
            #1;
            chk($sformatf("t34.r%0d.tready", r), 32'(tb_ready), 32'(tbl[r].exp_tready));
            chk($sformatf("t34.r%0d.tvalid", r), 32'(mif.tvalid), 32'(tbl[r].exp_tvalid));
            chk($sformatf("t34.r%0d.tdata", r), mif.tdata, tbl[r].exp_data);
            chk($sformatf("t34.r%0d.id", r), 32'(m_src_id), 32'(tbl[r].exp_id));
            tick();
        end

        // Single active input, back-to-back beats.
        do_reset("t35");
        tb_valid = 4'b0100; tb_data[2] = 32'h11; m_ready = 1'b1;
        expect_cyc("t35.c0", 1'b0, 32'h0, 2'd0, 4'h0);
        expect_cyc("t35.c1", 1'b0, 32'h0, 2'd0, 4'h4);
        tb_data[2] = 32'h22;
        expect_cyc("t35.c2", 1'b1, 32'h11, 2'd2, 4'h4);
        tb_data[2] = 32'h33;
        expect_cyc("t35.c3", 1'b1, 32'h22, 2'd2, 4'h4);
        tb_valid = 4'b0000;
        expect_cyc("t35.c4", 1'b1, 32'h33, 2'd2, 4'h0);
        expect_cyc("t35.c5", 1'b0, 32'h0, 2'd0, 4'h0);

        // Stalled sink fills main then skid, then drains in grant order.
        do_reset("t36");
        tb_valid = 4'b0011; tb_data[0] = 32'hC0; tb_data[1] = 32'hC1; m_ready = 1'b0;
        expect_cyc("t36.c0", 1'b0, 32'h0, 2'd0, 4'h0);
        expect_cyc("t36.c1", 1'b0, 32'h0, 2'd0, 4'h1);
        tb_data[0] = 32'hC2;
        expect_cyc("t36.c2", 1'b1, 32'hC0, 2'd0, 4'h2);
        tb_data[1] = 32'hC3;
        for (int k = 0; k < 4; k++) expect_cyc("t36.hold", 1'b1, 32'hC0, 2'd0, 4'h0);
        m_ready = 1'b1;
        expect_cyc("t36.c7", 1'b1, 32'hC0, 2'd0, 4'h0);
        expect_cyc("t36.c8", 1'b1, 32'hC1, 2'd1, 4'h1);
        tb_valid = 4'b0000;
        expect_cyc("t36.c9", 1'b1, 32'hC2, 2'd0, 4'h0);
        expect_cyc("t36.c10", 1'b0, 32'h0, 2'd0, 4'h0);

        // Flush with both stages full, then flush with an output handshake in the same cycle.
        do_reset("t37");
        tb_valid = 4'hF; m_ready = 1'b0;
        for (int i = 0; i < N; i++) tb_data[i] = 32'hD0 + 32'(i);
        expect_cyc("t37.c0", 1'b0, 32'h0, 2'd0, 4'h0);
        expect_cyc("t37.c1", 1'b0, 32'h0, 2'd0, 4'h1);
        expect_cyc("t37.c2", 1'b1, 32'hD0, 2'd0, 4'h2);
        flush = 1'b1;
        expect_cyc("t37.c3", 1'b1, 32'hD0, 2'd0, 4'h0);
        flush = 1'b0;
        expect_cyc("t37.c4", 1'b0, 32'h0, 2'd0, 4'h1);
        flush = 1'b1; m_ready = 1'b1;
        expect_cyc("t37.c5", 1'b1, 32'hD0, 2'd0, 4'h0);
        flush = 1'b0;
        expect_cyc("t37.c6", 1'b0, 32'h0, 2'd0, 4'h1);
        expect_cyc("t37.c7", 1'b1, 32'hD0, 2'd0, 4'h2);

        // Reset mid-stream with both stages full: buffered beats must vanish.
        do_reset("t38a");
        tb_valid = 4'hF; m_ready = 1'b0;
        for (int i = 0; i < N; i++) tb_data[i] = 32'hE0 + 32'(i);
        expect_cyc("t38.c0", 1'b0, 32'h0, 2'd0, 4'h0);
        expect_cyc("t38.c1", 1'b0, 32'h0, 2'd0, 4'h1);
        expect_cyc("t38.c2", 1'b1, 32'hE0, 2'd0, 4'h2);
        expect_cyc("t38.c3", 1'b1, 32'hE0, 2'd0, 4'h0);
        do_reset("t38b");
        tb_valid = 4'b1010; tb_data[1] = 32'hF1; tb_data[3] = 32'hF3; m_ready = 1'b1;
        expect_cyc("t38.d0", 1'b0, 32'h0, 2'd0, 4'h0);
        expect_cyc("t38.d1", 1'b0, 32'h0, 2'd0, 4'h2);
        tb_valid = 4'b1000;
        expect_cyc("t38.d2", 1'b1, 32'hF1, 2'd1, 4'h8);
        tb_valid = 4'b0000;
        expect_cyc("t38.d3", 1'b1, 32'hF3, 2'd3, 4'h0);
        expect_cyc("t38.d4", 1'b0, 32'h0, 2'd0, 4'h0);

        // Random traffic against a queue-based model of the two-entry output buffer.
        do_reset("rnd");
        for (int i = 0; i < N; i++) begin
            src_v[i] = 1'b0; src_d[i] = '0; src_seq[i] = 0; wait_cnt[i] = 0;
        end
        rdy_pct = 100; vld_pct = 100;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 500 == 0) begin
                case ((cyc / 500) % 4)
                    0: rdy_pct = 100;
                    1: rdy_pct = 70;
                    2: rdy_pct = 30;
                    default: rdy_pct = 90;
                endcase
                vld_pct = int'($urandom_range(20, 100));
            end
            for (int i = 0; i < N; i++) begin
                if (!src_v[i] && (int'($urandom_range(0, 99)) < vld_pct)) begin
                    src_v[i]   = 1'b1;
                    src_d[i]   = {8'(i), 24'(src_seq[i])};
                    src_seq[i] = src_seq[i] + 1;
                end
                tb_valid[i] = src_v[i];
                tb_data[i]  = src_d[i];
            end
            m_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            flush   = ($urandom_range(0, 99) == 0);
            #1;

            g      = mdl_pick(tb_valid, m_ptr);
            can    = m_active && !flush && (mq.size() < 2);
            exp_tr = (can && g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("rnd.tready", 32'(tb_ready), 32'(exp_tr));
            chk("rnd.tvalid", 32'(mif.tvalid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("rnd.tdata", mif.tdata, mq[0].d);
                chk("rnd.id", 32'(m_src_id), 32'(mq[0].id));
            end

            // Bound on accepts granted to others while an input waits, from observed handshakes.
            if (flush) begin
                for (int i = 0; i < N; i++) wait_cnt[i] = 0;
            end else if (|(tb_ready & tb_valid)) begin
                for (int i = 0; i < N; i++) begin
                    if (src_v[i] && tb_ready[i]) begin
                        n_checks++;
                        if (wait_cnt[i] > N - 1) begin
                            n_errors++;
                            $display("FAIL rnd.fair input %0d waited %0d accepts, required at most %0d",
                                     i, wait_cnt[i], N - 1);
                        end
                        wait_cnt[i] = 0;
                    end else if (src_v[i]) begin
                        wait_cnt[i] = wait_cnt[i] + 1;
                    end
                end
            end

            if (flush) begin
                mq.delete();
                m_ptr = 0;
            end else begin
                if (mq.size() > 0 && m_ready) void'(mq.pop_front());
                if (can && g >= 0) begin
                    nb.d  = src_d[g];
                    nb.id = 2'(g);
                    mq.push_back(nb);
                    m_ptr    = (g + 1) % N;
                    src_v[g] = 1'b0;
                end
            end
            m_active = 1'b1;
            tick();
        end
        flush    = 1'b0;
        tb_valid = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesting AXIS streams; SHALL be at least 2.
REQ-002 Parameter: ID_WIDTH, default $clog2(N_REQ), width of the source-ID sideband.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: axis_sif[N_REQ]  axis_if.s  TDATA_WIDTH  subordinate input streams (tvalid, tdata, tready).
REQ-006 Port: axis_mif  axis_if.m  TDATA_WIDTH  merged manager output stream.
REQ-007 Port: m_src_id  output  ID_WIDTH  index of the input that produced the beat on axis_mif; valid while axis_mif.tvalid is high.
REQ-008 Port: flush  input  1  synchronous discard of all buffered beats.
REQ-009 TDATA_WIDTH SHALL be taken from axis_mif; an elaboration-time fatal SHALL fire if any axis_sif TDATA_WIDTH differs.

Function
REQ-010 Output stage: main register (valid, data, id) plus one skid register (valid, data, id); both registered.
REQ-011 can_accept = !skid_valid && !flush (skid_valid is registered).
REQ-012 Grant: one-hot, combinational, round-robin among inputs with tvalid high. Search starts at ptr and wraps N_REQ-1 -> 0.
REQ-013 axis_sif[i].tready = can_accept && grant[i]. At most one tready is high per cycle. Inputs with no grant see tready low.
REQ-014 Accept: handshake on the granted input i.
REQ-015 On accept, ptr <= (i+1) mod N_REQ. Without an accept, ptr holds.
REQ-016 Accept while main empty, or main valid with axis_mif.tready high: beat loads main next cycle (latency 1 cycle).
REQ-017 Accept while main valid and axis_mif.tready low: beat loads skid.
REQ-018 axis_mif.tready high while skid valid: skid moves to main and skid empties.
REQ-019 Once main is valid, its data and id SHALL stay stable until the output handshake completes.
REQ-020 axis_mif.tvalid = main_valid; axis_mif.tdata = main_data; m_src_id = main_id.
REQ-021 Beat order: per-input order SHALL be preserved. No beat is duplicated or dropped, except by flush.
REQ-022 Throughput: with a continuously ready sink, one beat per cycle SHALL be sustained.
REQ-023 Fairness: with all N_REQ inputs valid, each input SHALL be granted once in every N_REQ consecutive accepts.
REQ-024 Flush cycle: no input is accepted.
REQ-025 Flush cycle, next state: main_valid=0, skid_valid=0, ptr=0. Any output handshake in that same cycle is still counted as completed.
REQ-026 Simultaneous output handshake and accept with skid empty: main reloads from the input, with no bubble.

Reset
REQ-027 While rst_n is low at a clock edge: main_valid=0, skid_valid=0, data=0, id=0, ptr=0.
REQ-028 Outputs in reset: axis_mif.tvalid=0, m_src_id=0, axis_mif.tdata=0.
REQ-029 All axis_sif tready SHALL be 0 during reset and in the first cycle after reset, with no accept in that cycle.
REQ-030 Reset asserted mid-transfer SHALL discard buffered beats without emitting them.

Structure
REQ-031 Shared package offnariscv_axis_pkg SHALL hold the helper function for ID width (clog2 with a minimum of 1) and the default N_REQ constant.
REQ-032 Round-robin selection SHALL be a sub-module rr_picker: combinational; inputs req[N_REQ], ptr; outputs one-hot grant and encoded index.
REQ-033 The output stage SHALL be inline in axis_rr_arbiter. Expected total size is 150-250 RTL lines.

Verification (N_REQ=4, TDATA_WIDTH=32)
REQ-034 Inputs 0..3 always valid with data 0xA0..0xA3, sink always ready, 8 cycles. Required output: A0,A1,A2,A3,A0,A1,A2,A3 with ids 0,1,2,3,0,1,2,3, no gaps after the first beat.
REQ-035 Only input 2 valid (0x11, 0x22, 0x33 back-to-back), sink ready. Required: three beats on consecutive cycles, m_src_id=2, order preserved.
REQ-036 Inputs 0 and 1 valid, sink tready low for 5 cycles, then high. Required: exactly two beats buffered (main+skid), all tready low after that, then drain in grant order with data unchanged.
REQ-037 Main and skid full, flush pulsed for 1 cycle. Required: axis_mif.tvalid=0 next cycle, no tready during flush, next grant starts at input 0.
REQ-038 rst_n low for 2 cycles mid-stream with main and skid full. Required: after release, tvalid=0, m_src_id=0, first accepted beat comes from the lowest-index valid input, no pre-reset beat emitted.
REQ-039 Random valid/ready on all inputs for 10k cycles against a scoreboard. Required: per-input order preserved, no loss or duplication, output stable while stalled, the REQ-023 fairness bound is never exceeded.
